gate_test_sequencer: RTL

//   Self-checking sequencer for a combinational N-input gate in the gate library.
//   On start, it walks every input vector 0..2^WIDTH-1 onto the gate inputs and waits SETTLE cycles.
//   It then samples the gate output and compares it against the truth table in parameter TRUTH.
//   It counts mismatches, records the first failing vector, and flags done/pass.
//   It sits beside the gate under test as on-chip BIST and as the bench driver.

---
 rtl/gate_test_sequencer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/gate_test_sequencer.sv
// -----------------------------------------------------------------------------
// gate_test_sequencer
//
// Built-in self-test sequencer for one combinational gate with WIDTH inputs.
// On a start request it drives every input vector 0 .. 2**WIDTH-1 onto the
// gate. Each vector is held for SETTLE cycles before the gate output is
// sampled and checked against the TRUTH table. The block counts mismatches
// (saturating), records the first failing vector, and raises done/pass when
// the sweep completes. All outputs are registered.
//
// Parameters
//   WIDTH   number of gate inputs (1..8); NVEC = 2**WIDTH vectors
//   TRUTH   expected gate output; bit i is the expected y for input vector i
//   SETTLE  cycles each vector is held before sampling (>= 1)
//   ERRW    width of the saturating mismatch counter
//
// Ports
//   clk_i         rising-edge clock
//   rst_ni        asynchronous active-low reset
//   start_i       level-sampled run request, honoured only in IDLE or DONE
//   a_out_o       vector driven onto the gate inputs (bit 0 = first input)
//   y_in_i        gate output, sampled only in CHECK
//   busy_o        high while a run is in progress (WAIT/CHECK)
//   done_o        high in DONE until the next start or reset
//   pass_o        done and no mismatches seen
//   err_cnt_o     saturating mismatch count for the current/last run
//   fail_valid_o  at least one mismatch seen in this run
//   fail_vec_o    first mismatching vector, meaningful when fail_valid_o is set
// -----------------------------------------------------------------------------
module gate_test_sequencer #(
   parameter int unsigned            WIDTH  = 2,
   parameter logic [(1<<WIDTH)-1:0]  TRUTH  = 4'b1000,
   parameter int unsigned            SETTLE = 2,
   parameter int unsigned            ERRW   = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   output logic [WIDTH-1:0] a_out_o,
   input  logic             y_in_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             pass_o,
   output logic [ERRW-1:0]  err_cnt_o,
   output logic             fail_valid_o,
   output logic [WIDTH-1:0] fail_vec_o
);

   localparam int unsigned NVEC = 1 << WIDTH;
   // The settle counter only has to reach SETTLE-1.
   localparam int unsigned CNTW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_CHECK = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   state_e           state_q;
   logic [WIDTH-1:0] vec_q;
   logic [CNTW-1:0]  cnt_q;
   logic [WIDTH-1:0] a_out_q;
   logic             busy_q;
   logic             done_q;
   logic             pass_q;
   logic [ERRW-1:0]  err_cnt_q;
   logic [ERRW-1:0]  err_cnt_d;
   logic             fail_valid_q;
   logic [WIDTH-1:0] fail_vec_q;

   logic             mismatch;
   logic             last_vec;
   logic             settled;

   // Compare the gate output with the expected truth-table bit for the
   // current vector. The counter value that would be stored in CHECK is
   // worked out here, because the registered pass flag has to see it in the
   // same cycle the run finishes. The counter sticks at all-ones.
   always_comb begin
      mismatch  = (y_in_i != TRUTH[vec_q]);
      err_cnt_d = err_cnt_q;
      if (mismatch && (err_cnt_q != {ERRW{1'b1}})) begin
         err_cnt_d = err_cnt_q + ERRW'(1);
      end
   end

   assign last_vec = (vec_q == WIDTH'(NVEC - 1));
   assign settled  = (cnt_q == CNTW'(SETTLE - 1));

   // Main sequencer. Every output is a register written here. a_out is
   // updated on the same edge that vec advances, so the new vector is
   // already on the gate during its first WAIT cycle. A start request
   // during WAIT/CHECK is simply not looked at, so a run cannot be restarted.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= S_IDLE;
         vec_q        <= '0;
         cnt_q        <= '0;
         a_out_q      <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         err_cnt_q    <= '0;
         fail_valid_q <= 1'b0;
         fail_vec_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start_i) begin
                  state_q      <= S_WAIT;
                  vec_q        <= '0;
                  cnt_q        <= '0;
                  a_out_q      <= '0;
                  busy_q       <= 1'b1;
                  done_q       <= 1'b0;
                  pass_q       <= 1'b0;
                  err_cnt_q    <= '0;
                  fail_valid_q <= 1'b0;
                  fail_vec_q   <= '0;
               end
            end

            S_WAIT: begin
               if (settled) begin
                  state_q <= S_CHECK;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNTW'(1);
               end
            end

            S_CHECK: begin
               err_cnt_q <= err_cnt_d;
               if (mismatch && !fail_valid_q) begin
                  fail_valid_q <= 1'b1;
                  fail_vec_q   <= vec_q;
               end
               if (last_vec) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= (err_cnt_d == '0);
                  a_out_q <= '0;
               end else begin
                  state_q <= S_WAIT;
                  vec_q   <= vec_q + WIDTH'(1);
                  a_out_q <= vec_q + WIDTH'(1);
                  cnt_q   <= '0;
               end
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign a_out_o      = a_out_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign pass_o       = pass_q;
   assign err_cnt_o    = err_cnt_q;
   assign fail_valid_o = fail_valid_q;
   assign fail_vec_o   = fail_vec_q;

endmodule
